// File: rtl/gpr_reg_mp_if.sv
// Bus bundle for gpr_reg_mp: two write ports, three read ports
// and the clear-sequence control/status pair.
interface gpr_reg_mp_if #(
    parameter int DW = 32,
    parameter int AW = 5
);
    logic          clr_req_i;
    logic          busy_o;
    logic          we1_i;
    logic [AW-1:0] waddr1_i;
    logic [DW-1:0] wdata1_i;
    logic          we2_i;
    logic [AW-1:0] waddr2_i;
    logic [DW-1:0] wdata2_i;
    logic [AW-1:0] raddr1_i;
    logic [AW-1:0] raddr2_i;
    logic [AW-1:0] raddr3_i;
    logic [DW-1:0] rdata1_o;
    logic [DW-1:0] rdata2_o;
    logic [DW-1:0] rdata3_o;

    modport master (
        output clr_req_i,
        output we1_i, waddr1_i, wdata1_i,
        output we2_i, waddr2_i, wdata2_i,
        output raddr1_i, raddr2_i, raddr3_i,
        input  busy_o,
        input  rdata1_o, rdata2_o, rdata3_o
    );

    modport slave (
        input  clr_req_i,
        input  we1_i, waddr1_i, wdata1_i,
        input  we2_i, waddr2_i, wdata2_i,
        input  raddr1_i, raddr2_i, raddr3_i,
        output busy_o,
        output rdata1_o, rdata2_o, rdata3_o
    );
endinterface

// File: rtl/gpr_reg_mp.sv
// 2W/3R register file with self-clearing sequencer.
// GPR_BYPASS_EN: forward same-cycle write data to read ports.
module gpr_reg_mp #(
    parameter int DW       = 32,
    parameter int AW       = 5,
    parameter int ZERO_REG = 1
) (
    input logic         clk,
    input logic         rst_n,
    gpr_reg_mp_if.slave bus
);
    localparam int DEPTH = 2 ** AW;
    localparam logic [AW-1:0] FIRST =
        (ZERO_REG != 0) ? AW'(1) : '0;
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    state_t        state_q;
    logic [AW-1:0] cnt_q;
    logic          busy_q;
    logic [DW-1:0] mem_q [DEPTH];

    logic          wr1;
    logic          wr2;
    logic [AW-1:0] raddr [3];
    logic [DW-1:0] rdata [3];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= CLEAR;
            cnt_q   <= FIRST;
            busy_q  <= 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.clr_req_i) begin
                        state_q <= CLEAR;
                        cnt_q   <= FIRST;
                        busy_q  <= 1'b1;
                    end
                end
                CLEAR: begin
                    if (cnt_q == LAST) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + AW'(1);
                    end
                end
                default: begin
                    state_q <= CLEAR;
                    cnt_q   <= FIRST;
                    busy_q  <= 1'b1;
                end
            endcase
        end
    end

    // Hardwired r0 never takes a write, so it needs no storage update.
    assign wr1 = bus.we1_i && !busy_q &&
                 !((ZERO_REG != 0) && (bus.waddr1_i == '0));
    assign wr2 = bus.we2_i && !busy_q &&
                 !((ZERO_REG != 0) && (bus.waddr2_i == '0));

    // Port 2 is written last so it wins a same-address collision.
    always_ff @(posedge clk) begin
        if (busy_q) begin
            if (rst_n) begin
                mem_q[cnt_q] <= '0;
            end
        end else begin
            if (wr1) begin
                mem_q[bus.waddr1_i] <= bus.wdata1_i;
            end
            if (wr2) begin
                mem_q[bus.waddr2_i] <= bus.wdata2_i;
            end
        end
    end

    assign raddr[0] = bus.raddr1_i;
    assign raddr[1] = bus.raddr2_i;
    assign raddr[2] = bus.raddr3_i;

    for (genvar g = 0; g < 3; g++) begin : g_rd
        always_comb begin
            rdata[g] = mem_q[raddr[g]];
            if ((ZERO_REG != 0) && (raddr[g] == '0)) begin
                rdata[g] = '0;
            end
`ifdef GPR_BYPASS_EN
            if (wr1 && (raddr[g] == bus.waddr1_i)) begin
                rdata[g] = bus.wdata1_i;
            end
            if (wr2 && (raddr[g] == bus.waddr2_i)) begin
                rdata[g] = bus.wdata2_i;
            end
`endif
        end
    end

    assign bus.busy_o   = busy_q;
    assign bus.rdata1_o = rdata[0];
    assign bus.rdata2_o = rdata[1];
    assign bus.rdata3_o = rdata[2];
endmodule

// File: tb/tb_gpr_reg_mp.sv
// Bench for gpr_reg_mp: default instance plus a ZERO_REG=0 instance,
// read expectations queued from a reference model.
module tb_gpr_reg_mp;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    gpr_reg_mp_if #(.DW(32), .AW(5)) ifa ();
    gpr_reg_mp_if #(.DW(32), .AW(5)) ifb ();

    gpr_reg_mp #(.DW(32), .AW(5), .ZERO_REG(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(ifa.slave)
    );
    gpr_reg_mp #(.DW(32), .AW(5), .ZERO_REG(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(ifb.slave)
    );

    int total = 0;
    int bad = 0;
    logic [31:0] sbq[$];
    logic [31:0] mdl[32];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_a();
        ifa.clr_req_i = 0;
        ifa.we1_i = 0; ifa.waddr1_i = 0; ifa.wdata1_i = 0;
        ifa.we2_i = 0; ifa.waddr2_i = 0; ifa.wdata2_i = 0;
        ifa.raddr1_i = 0; ifa.raddr2_i = 0; ifa.raddr3_i = 0;
    endtask

    task automatic idle_b();
        ifb.clr_req_i = 0;
        ifb.we1_i = 0; ifb.waddr1_i = 0; ifb.wdata1_i = 0;
        ifb.we2_i = 0; ifb.waddr2_i = 0; ifb.wdata2_i = 0;
        ifb.raddr1_i = 0; ifb.raddr2_i = 0; ifb.raddr3_i = 0;
    endtask

    task automatic clear_model();
        for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
    endtask

    // Expected read of instance A while it is idle.
    function automatic logic [31:0] exp_a(input logic [4:0] a);
        logic [31:0] v;
        v = (a == 0) ? 32'h0 : mdl[a];
`ifdef GPR_BYPASS_EN
        if (ifa.we1_i && ifa.waddr1_i != 0 && ifa.waddr1_i == a)
            v = ifa.wdata1_i;
        if (ifa.we2_i && ifa.waddr2_i != 0 && ifa.waddr2_i == a)
            v = ifa.wdata2_i;
`endif
        return v;
    endfunction

    task automatic commit_a();
        if (ifa.we1_i && ifa.waddr1_i != 0) mdl[ifa.waddr1_i] = ifa.wdata1_i;
        if (ifa.we2_i && ifa.waddr2_i != 0) mdl[ifa.waddr2_i] = ifa.wdata2_i;
    endtask

    task automatic test_reset();
        int na, nb, g;
        logic [31:0] e;
        idle_a(); idle_b();
        rst_n = 0;
        tick(); tick();
        total++;
        if (ifa.busy_o !== 1'b1) begin
            bad++; $display("FAIL rst_busy_a got=%b exp=1", ifa.busy_o);
        end
        total++;
        if (ifb.busy_o !== 1'b1) begin
            bad++; $display("FAIL rst_busy_b got=%b exp=1", ifb.busy_o);
        end
        rst_n = 1;
        ifa.we1_i = 1; ifa.waddr1_i = 7; ifa.wdata1_i = 32'hDEADBEEF;
        ifb.we1_i = 1; ifb.waddr1_i = 7; ifb.wdata1_i = 32'hDEADBEEF;
        na = 0; nb = 0; g = 0;
        while ((ifa.busy_o || ifb.busy_o) && g < 100) begin
            if (ifa.busy_o) na++; else ifa.we1_i = 0;
            if (ifb.busy_o) nb++; else ifb.we1_i = 0;
            g++;
            tick();
        end
        idle_a(); idle_b();
        clear_model();
        total++;
        if (na != 31) begin
            bad++; $display("FAIL busy_len_a got=%0d exp=31", na);
        end
        total++;
        if (nb != 32) begin
            bad++; $display("FAIL busy_len_b got=%0d exp=32", nb);
        end
        for (int i = 0; i < 32; i++) begin
            ifa.raddr1_i = 5'(i); ifa.raddr2_i = 5'(i); ifa.raddr3_i = 5'(i);
            ifb.raddr1_i = 5'(i);
            sbq.push_back(exp_a(5'(i)));
            sbq.push_back(exp_a(5'(i)));
            sbq.push_back(exp_a(5'(i)));
            sbq.push_back(32'h0);
            #1;
            e = sbq.pop_front(); total++;
            if (ifa.rdata1_o !== e) begin
                bad++; $display("FAIL clr_rd1 a=%0d got=%h exp=%h", i, ifa.rdata1_o, e);
            end
            e = sbq.pop_front(); total++;
            if (ifa.rdata2_o !== e) begin
                bad++; $display("FAIL clr_rd2 a=%0d got=%h exp=%h", i, ifa.rdata2_o, e);
            end
            e = sbq.pop_front(); total++;
            if (ifa.rdata3_o !== e) begin
                bad++; $display("FAIL clr_rd3 a=%0d got=%h exp=%h", i, ifa.rdata3_o, e);
            end
            e = sbq.pop_front(); total++;
            if (ifb.rdata1_o !== e) begin
                bad++; $display("FAIL clr_rd_b a=%0d got=%h exp=%h", i, ifb.rdata1_o, e);
            end
        end
        idle_a(); idle_b();
    endtask

    task automatic test_dual_write();
        logic [31:0] e;
        ifa.we1_i = 1; ifa.waddr1_i = 5; ifa.wdata1_i = 32'h12345678;
        ifa.we2_i = 1; ifa.waddr2_i = 9; ifa.wdata2_i = 32'hCAFEF00D;
        commit_a();
        tick();
        idle_a();
        ifa.raddr1_i = 5; ifa.raddr2_i = 9;
        sbq.push_back(exp_a(5));
        sbq.push_back(exp_a(9));
        #1;
        e = sbq.pop_front(); total++;
        if (ifa.rdata1_o !== e) begin
            bad++; $display("FAIL dual_w1 got=%h exp=%h", ifa.rdata1_o, e);
        end
        e = sbq.pop_front(); total++;
        if (ifa.rdata2_o !== e) begin
            bad++; $display("FAIL dual_w2 got=%h exp=%h", ifa.rdata2_o, e);
        end
    endtask

    task automatic test_collision();
        logic [31:0] e;
        ifa.we1_i = 1; ifa.waddr1_i = 3; ifa.wdata1_i = 32'h11111111;
        ifa.we2_i = 1; ifa.waddr2_i = 3; ifa.wdata2_i = 32'h22222222;
        commit_a();
        tick();
        idle_a();
        ifa.raddr1_i = 3;
        sbq.push_back(exp_a(3));
        #1;
        e = sbq.pop_front(); total++;
        if (ifa.rdata1_o !== e) begin
            bad++; $display("FAIL collision got=%h exp=%h", ifa.rdata1_o, e);
        end
    endtask

    task automatic test_zero_reg();
        int nb, g;
        logic [31:0] e;
        ifa.we1_i = 1; ifa.waddr1_i = 0; ifa.wdata1_i = 32'hFFFFFFFF;
        ifb.we1_i = 1; ifb.waddr1_i = 0; ifb.wdata1_i = 32'hFFFFFFFF;
        commit_a();
        tick();
        idle_a(); idle_b();
        sbq.push_back(exp_a(0));
        sbq.push_back(32'hFFFFFFFF);
        #1;
        e = sbq.pop_front(); total++;
        if (ifa.rdata1_o !== e) begin
            bad++; $display("FAIL zero_a got=%h exp=%h", ifa.rdata1_o, e);
        end
        e = sbq.pop_front(); total++;
        if (ifb.rdata1_o !== e) begin
            bad++; $display("FAIL zero_b got=%h exp=%h", ifb.rdata1_o, e);
        end
        ifb.clr_req_i = 1;
        tick();
        ifb.clr_req_i = 0;
        nb = 0; g = 0;
        while (ifb.busy_o && g < 100) begin
            nb++; g++;
            tick();
        end
        total++;
        if (nb != 32) begin
            bad++; $display("FAIL busy_len_b_req got=%0d exp=32", nb);
        end
        sbq.push_back(32'h0);
        #1;
        e = sbq.pop_front(); total++;
        if (ifb.rdata1_o !== e) begin
            bad++; $display("FAIL zero_b_clr got=%h exp=%h", ifb.rdata1_o, e);
        end
    endtask

    task automatic test_clear_req();
        int n;
        logic [31:0] e;
        ifa.we1_i = 1; ifa.waddr1_i = 31; ifa.wdata1_i = 32'hA5A5A5A5;
        commit_a();
        tick();
        idle_a();
        ifa.clr_req_i = 1;
        #1;
        total++;
        if (ifa.busy_o !== 1'b0) begin
            bad++; $display("FAIL busy_pre_req got=%b exp=0", ifa.busy_o);
        end
        tick();
        ifa.clr_req_i = 0;
        total++;
        if (ifa.busy_o !== 1'b1) begin
            bad++; $display("FAIL busy_post_req got=%b exp=1", ifa.busy_o);
        end
        ifa.raddr1_i = 31;
        n = 0;
        while (ifa.busy_o && n < 100) begin
            sbq.push_back(32'hA5A5A5A5);
            ifa.clr_req_i = (n == 10);
            #1;
            e = sbq.pop_front(); total++;
            if (ifa.rdata1_o !== e) begin
                bad++; $display("FAIL stale31 cyc=%0d got=%h exp=%h", n, ifa.rdata1_o, e);
            end
            n++;
            tick();
        end
        ifa.clr_req_i = 0;
        clear_model();
        total++;
        if (n != 31) begin
            bad++; $display("FAIL busy_len_req got=%0d exp=31", n);
        end
        sbq.push_back(exp_a(31));
        #1;
        e = sbq.pop_front(); total++;
        if (ifa.rdata1_o !== e) begin
            bad++; $display("FAIL cleared31 got=%h exp=%h", ifa.rdata1_o, e);
        end
        idle_a();
    endtask

    task automatic test_bypass();
        logic [31:0] e;
        ifa.we2_i = 1; ifa.waddr2_i = 12; ifa.wdata2_i = 32'h00000001;
        commit_a();
        tick();
        idle_a();
        ifa.we2_i = 1; ifa.waddr2_i = 12; ifa.wdata2_i = 32'h0BADC0DE;
        ifa.raddr3_i = 12;
        sbq.push_back(exp_a(12));
        #1;
        e = sbq.pop_front(); total++;
        if (ifa.rdata3_o !== e) begin
            bad++; $display("FAIL bypass_same got=%h exp=%h", ifa.rdata3_o, e);
        end
        commit_a();
        tick();
        idle_a();
        ifa.raddr3_i = 12;
        sbq.push_back(exp_a(12));
        #1;
        e = sbq.pop_front(); total++;
        if (ifa.rdata3_o !== e) begin
            bad++; $display("FAIL bypass_next got=%h exp=%h", ifa.rdata3_o, e);
        end
    endtask

    task automatic test_reset_mid_clear();
        int na, nb, g;
        logic [31:0] e;
        ifa.clr_req_i = 1;
        tick();
        ifa.clr_req_i = 0;
        repeat (5) tick();
        rst_n = 0;
        ifa.we1_i = 1; ifa.waddr1_i = 20; ifa.wdata1_i = 32'h00000077;
        #1;
        total++;
        if (ifa.busy_o !== 1'b1) begin
            bad++; $display("FAIL busy_in_rst got=%b exp=1", ifa.busy_o);
        end
        tick();
        rst_n = 1;
        idle_a();
        na = 0; nb = 0; g = 0;
        while ((ifa.busy_o || ifb.busy_o) && g < 100) begin
            if (ifa.busy_o) na++;
            if (ifb.busy_o) nb++;
            g++;
            tick();
        end
        clear_model();
        total++;
        if (na != 31) begin
            bad++; $display("FAIL busy_len_rst_a got=%0d exp=31", na);
        end
        total++;
        if (nb != 32) begin
            bad++; $display("FAIL busy_len_rst_b got=%0d exp=32", nb);
        end
        ifa.raddr1_i = 20; ifa.raddr2_i = 12;
        sbq.push_back(exp_a(20));
        sbq.push_back(exp_a(12));
        #1;
        e = sbq.pop_front(); total++;
        if (ifa.rdata1_o !== e) begin
            bad++; $display("FAIL rst_lost_wr got=%h exp=%h", ifa.rdata1_o, e);
        end
        e = sbq.pop_front(); total++;
        if (ifa.rdata2_o !== e) begin
            bad++; $display("FAIL rst_clr12 got=%h exp=%h", ifa.rdata2_o, e);
        end
        idle_a();
    endtask

    task automatic test_back_to_back();
        logic [31:0] e;
        for (int c = 0; c < 60; c++) begin
            ifa.we1_i = 1'($urandom_range(0, 1));
            ifa.we2_i = 1'($urandom_range(0, 1));
            ifa.waddr1_i = 5'($urandom_range(0, 31));
            ifa.waddr2_i = ($urandom_range(0, 3) == 0) ? ifa.waddr1_i
                                                       : 5'($urandom_range(0, 31));
            ifa.wdata1_i = $urandom;
            ifa.wdata2_i = $urandom;
            ifa.raddr1_i = ifa.waddr1_i;
            ifa.raddr2_i = ifa.waddr2_i;
            ifa.raddr3_i = 5'($urandom_range(0, 31));
            sbq.push_back(exp_a(ifa.raddr1_i));
            sbq.push_back(exp_a(ifa.raddr2_i));
            sbq.push_back(exp_a(ifa.raddr3_i));
            #1;
            e = sbq.pop_front(); total++;
            if (ifa.rdata1_o !== e) begin
                bad++; $display("FAIL b2b_rd1 cyc=%0d got=%h exp=%h", c, ifa.rdata1_o, e);
            end
            e = sbq.pop_front(); total++;
            if (ifa.rdata2_o !== e) begin
                bad++; $display("FAIL b2b_rd2 cyc=%0d got=%h exp=%h", c, ifa.rdata2_o, e);
            end
            e = sbq.pop_front(); total++;
            if (ifa.rdata3_o !== e) begin
                bad++; $display("FAIL b2b_rd3 cyc=%0d got=%h exp=%h", c, ifa.rdata3_o, e);
            end
            commit_a();
            tick();
        end
        idle_a();
        for (int i = 0; i < 32; i++) begin
            ifa.raddr1_i = 5'(i);
            sbq.push_back(exp_a(5'(i)));
            #1;
            e = sbq.pop_front(); total++;
            if (ifa.rdata1_o !== e) begin
                bad++; $display("FAIL b2b_final a=%0d got=%h exp=%h", i, ifa.rdata1_o, e);
            end
        end
    endtask

    initial begin
        clear_model();
        test_reset();
        test_dual_write();
        test_collision();
        test_zero_reg();
        test_clear_req();
        test_bypass();
        test_reset_mid_clear();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
